// File: rtl/slc_req_sched_pkg.sv
// Shared types and constants for the single-line-cache request scheduler.
package slc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FILL_REQ,
    FILL_WAIT,
    FILL_WR,
    RESP
  } sched_state_e;

  localparam logic [15:0] SLC_MISS_POISON = 16'hDEAD;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned cache_lsb);
    logic [63:0] mask;
    mask = {64{1'b1}} << cache_lsb;
    return addr & mask;
  endfunction

endpackage

// File: rtl/slc_req_sched_if.sv
// Requester, cache and backing-memory signals of the scheduler, bundled with master/slave views.
interface slc_req_sched_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 52,
  parameter int unsigned DATA_WIDTH = 512
);
  logic [NUM_REQ-1:0]            req_val;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_gnt;
  logic [NUM_REQ-1:0]            rsp_val;
  logic                          rsp_hit;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          busy;
  logic                          cache_val;
  logic                          cache_rw;
  logic [ADDR_WIDTH-1:0]         cache_addr;
  logic [DATA_WIDTH-1:0]         cache_wdata;
  logic                          cache_rdy;
  logic                          cache_hit;
  logic [DATA_WIDTH-1:0]         cache_rdata;
  logic                          mem_req_val;
  logic [ADDR_WIDTH-1:0]         mem_req_addr;
  logic                          mem_req_rdy;
  logic                          mem_rsp_val;
  logic [DATA_WIDTH-1:0]         mem_rsp_data;

  modport slave (
    input  req_val, req_rw, req_addr, req_wdata,
    input  cache_rdy, cache_hit, cache_rdata,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data,
    output req_gnt, rsp_val, rsp_hit, rsp_rdata, busy,
    output cache_val, cache_rw, cache_addr, cache_wdata,
    output mem_req_val, mem_req_addr
  );

  modport master (
    output req_val, req_rw, req_addr, req_wdata,
    output cache_rdy, cache_hit, cache_rdata,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data,
    input  req_gnt, rsp_val, rsp_hit, rsp_rdata, busy,
    input  cache_val, cache_rw, cache_addr, cache_wdata,
    input  mem_req_val, mem_req_addr
  );
endinterface

// File: rtl/slc_req_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module slc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDXW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    idx
);

  logic            found;
  logic [IDXW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((32'(ptr) + k) % NUM_REQ);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slc_req_sched.sv
// Round-robin scheduler serialising NUM_REQ requesters onto one single-line cache port.
// Define SLC_SCHED_MISS_FILL_EN to fill the line from backing memory on a read miss.
module slc_req_sched
  import slc_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 52,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned CACHE_LINE_SIZE = 64
) (
  input logic            clk,
  input logic            rst,
  slc_req_sched_if.slave bus
);

  localparam int unsigned IDXW      = $clog2(NUM_REQ);
  localparam int unsigned CACHE_LSB = $clog2(CACHE_LINE_SIZE);
  localparam logic [DATA_WIDTH-1:0] POISON_LINE = {(DATA_WIDTH/16){SLC_MISS_POISON}};

  sched_state_e          state_q;
  logic [IDXW-1:0]       rr_ptr_q;
  logic [IDXW-1:0]       owner_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NUM_REQ-1:0]    rsp_val_q;
  logic                  rsp_hit_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDXW-1:0]       arb_idx;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    owner_oh;

  assign arb_en   = rst && (state_q == IDLE);
  assign owner_oh = NUM_REQ'(1) << owner_q;

  slc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (bus.req_val),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grant and cache strobe are same-cycle handshakes, so they bypass the output registers.
  assign bus.req_gnt     = arb_gnt;
  assign bus.cache_val   = rst && ((state_q == ISSUE) || (state_q == FILL_WR)) && bus.cache_rdy;
  assign bus.cache_rw    = rw_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = wdata_q;
  assign bus.rsp_val     = rsp_val_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef SLC_SCHED_MISS_FILL_EN
  logic                  mem_req_val_q;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q;

  assign bus.mem_req_val  = mem_req_val_q;
  assign bus.mem_req_addr = mem_req_addr_q;
`else
  logic unused_mem_inputs;

  assign bus.mem_req_val  = 1'b0;
  assign bus.mem_req_addr = '0;
  assign unused_mem_inputs = ^{bus.mem_req_rdy, bus.mem_rsp_val, bus.mem_rsp_data};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_val_q   <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SLC_SCHED_MISS_FILL_EN
      mem_req_val_q  <= 1'b0;
      mem_req_addr_q <= '0;
`endif
    end else begin
      rsp_val_q <= '0;
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            owner_q  <= arb_idx;
            rw_q     <= bus.req_rw[arb_idx];
            addr_q   <= bus.req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q  <= bus.req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_q <= (arb_idx == IDXW'(NUM_REQ-1)) ? '0 : arb_idx + IDXW'(1);
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cache_rdy) state_q <= WAIT;
        end
        WAIT: begin
          if (!rw_q) begin
            state_q     <= RESP;
            rsp_val_q   <= owner_oh;
            rsp_hit_q   <= bus.cache_hit;
            rsp_rdata_q <= '0;
          end else if (bus.cache_hit) begin
            state_q     <= RESP;
            rsp_val_q   <= owner_oh;
            rsp_hit_q   <= 1'b1;
            rsp_rdata_q <= bus.cache_rdata;
          end else begin
`ifdef SLC_SCHED_MISS_FILL_EN
            state_q        <= FILL_REQ;
            mem_req_val_q  <= 1'b1;
            mem_req_addr_q <= ADDR_WIDTH'(line_align(64'(addr_q), CACHE_LSB));
`else
            state_q     <= RESP;
            rsp_val_q   <= owner_oh;
            rsp_hit_q   <= 1'b0;
            rsp_rdata_q <= POISON_LINE;
`endif
          end
        end
`ifdef SLC_SCHED_MISS_FILL_EN
        FILL_REQ: begin
          if (bus.mem_req_rdy) begin
            mem_req_val_q <= 1'b0;
            state_q       <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          // The fill line reuses the write-data register; the cache write goes to the original address.
          if (bus.mem_rsp_val) begin
            wdata_q <= bus.mem_rsp_data;
            rw_q    <= 1'b0;
            state_q <= FILL_WR;
          end
        end
        FILL_WR: begin
          if (bus.cache_rdy) begin
            state_q     <= RESP;
            rsp_val_q   <= owner_oh;
            rsp_hit_q   <= 1'b0;
            rsp_rdata_q <= wdata_q;
          end
        end
`endif
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
